addressing_sequencer: RTL and testbench
=======================================

# addressing_sequencer

- Parametrised operand/effective-address sequencer for the 6502 core.
- Sits between `instruction_decode` and the bus. After an opcode fetch, the decoder hands it an addressing mode and an access kind. It then generates the operand-fetch, index, page-fix, data and read-modify-write bus cycles, and reports `done`.
- Supports zero-page, indexed and absolute modes, a relocatable zero page, banked (>16-bit) addresses and a selectable page-cross penalty.

## Interface
Parameters:
- `ADDR_W`, 16: address width, legal range 16..24. Bits above 15 always come from `pc`.
- `ZP_BASE`, 8'h00: bits 15:8 of every zero-page address.
- `PAGE_PENALTY`, 1:
  - 1: indexed reads take the FIX cycle only on page cross.
  - 0: the FIX cycle is always taken.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `res`  in  1  reset, synchronous and active-high. Has priority over `rdy`.
- `rdy`  in  1  0 = stall. State and registers hold; `pc_inc`, `alu_req` and `done` are forced to 0.
- `start`  in  1  begin a sequence. Sampled only in IDLE with `rdy`=1.
- `mode`  in  3  0 IMP, 1 IMM, 2 ZPG, 3 ZPX, 4 ZPY, 5 ABS, 6 ABX, 7 ABY.
- `kind`  in  2  0 READ, 1 WRITE, 2 RMW, 3 treated as READ. IMM and IMP always behave as READ.
- `pc`  in  ADDR_W  current program counter, pointing at the first operand byte.
- `data_in`  in  8  read data bus.
- `index_x`, `index_y`  in  8  index register values.
- `wdata`  in  8  store data for WRITE, or ALU result for RMW.
- `addr`  out  ADDR_W  effective bus address. Valid when `addr_sel`=1.
- `addr_sel`  out  1  1 = `addr` drives the bus, 0 = `pc` drives the bus.
- `rw`  out  1  1 read, 0 write.
- `pc_inc`  out  1  increment the PC at this edge.
- `data_out`  out  8  write data. Valid when `rw`=0.
- `operand`  out  8  latched read data.
- `alu_req`  out  1  RMW modify cycle. `wdata` is sampled at this edge.
- `busy`  out  1  1 in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.

## Operation
- `mode` and `kind` are captured on start.
- States: IDLE, FETCH_LO, FETCH_HI, ZP_IDX, FIX, DATA, RMW_DUMMY, RMW_WRITE, DONE.
- IDLE with start:
  - IMP goes to DONE.
  - All other modes go to FETCH_LO.
- FETCH_LO: read at `pc`, `pc_inc`=1, `lo`<=`data_in`.
  - IMM: `operand`<=`data_in`, then DONE.
  - ZPG: DATA.
  - ZPX, ZPY: ZP_IDX.
  - Absolute modes: FETCH_HI.
- ZP_IDX: dummy read at {bank,`ZP_BASE`,`lo`}. `lo`<=`lo`+idx, mod 256 (no carry into the page). Then DATA.
- FETCH_HI: read at `pc`, `pc_inc`=1, `hi`<=`data_in`.
  - ABX/ABY: `lo`<=`lo`+idx and carry is recorded.
  - Go to FIX if the mode is indexed AND (`kind`≠READ OR carry OR `PAGE_PENALTY`=0). Otherwise go to DATA.
- FIX: dummy read at {bank,`hi`,`lo`}. `hi`<=`hi`+carry, wrapping 8 bits inside the bank. Then DATA.
- DATA: address is {bank,`hi`,`lo`}. Zero-page modes use `hi`=`ZP_BASE`.
  - READ: `operand`<=`data_in`, then DONE.
  - WRITE: `rw`=0, `data_out`=`wdata`, then DONE.
  - RMW: `operand`<=`data_in`, then RMW_DUMMY.
- RMW_DUMMY: `rw`=0, `data_out`=`operand` (old value), `alu_req`=1, `result`<=`wdata`. Then RMW_WRITE.
- RMW_WRITE: `rw`=0, `data_out`=`result`. Then DONE.
- DONE: `done`=1, `busy`=1. Next state is IDLE. A start in DONE is ignored.
- IDLE: `addr_sel`=0, `rw`=1.
- bank = `pc`[ADDR_W-1:16]. The bank is empty when `ADDR_W`=16.

## Timing
- Reset: the registered state is IDLE on the edge after `res`=1. The next cycle shows:
  - `addr`=0, `addr_sel`=0, `rw`=1, `pc_inc`=0, `data_out`=0, `operand`=0, `alu_req`=0, `busy`=0, `done`=0.
  - Internal `lo`, `hi`, `result` and carry are cleared.
  - Reset mid-sequence aborts with no further write cycle.
- Cycles from the start edge to the end of DONE, inclusive:
  - IMP 1, IMM 2.
  - ZPG 3. ZPX/ZPY 4.
  - ABS 4.
  - ABX/ABY READ: 4, or 5 on page cross or when `PAGE_PENALTY`=0. ABX/ABY WRITE: 5.
  - RMW adds 2 to the corresponding WRITE count.
- The stalled cycle repeats with identical `addr`/`rw`/`data_out`. An edge with `rdy`=0 never counts as a cycle.
- `pc_inc` pulses exactly once per operand byte regardless of stalls.
- `rw`=0 only in DATA(WRITE), RMW_DUMMY and RMW_WRITE.
- Outputs are decoded from the registered state plus registers; `addr` changes only at edges.

## Test plan
- ZPX READ, `ZP_BASE`=00, `lo`=F0, X=20, mem[0010]=5A:
  - dummy read at 00F0, then read at 0010.
  - `operand`=5A, `done` on cycle 4, `pc_inc` count 1.
- ABX READ, bytes 10,12, X=05 -> read at 1215, `done` cycle 4.
- ABX READ, bytes FF,12, X=01 -> FIX read at 1200, then DATA at 1300, `done` cycle 5.
- Rerun both ABX cases with `PAGE_PENALTY`=0 -> both take 5 cycles.
- RMW ZPG 42, mem=81, `wdata`=02:
  - read 0042, write 81, write 02.
  - `alu_req` high exactly 1 cycle, `done` cycle 5.
- ABS WRITE 3456, `wdata`=C3, with `rdy`=0 for 3 cycles during FETCH_HI:
  - total `pc_inc` pulses = 2.
  - single write of C3 at 3456, `done` after 4 ready cycles.
- `ADDR_W`=20, `ZP_BASE`=03, `pc`=5xxxx, ZPG operand 42 -> data address 50342.
- Assert `res` during RMW_DUMMY:
  - next cycle: `busy`=0, `rw`=1, no RMW_WRITE.
  - a new start succeeds.

Source files
------------

// File: rtl/addressing_sequencer.sv
// Operand / effective-address sequencer for the 6502 core: walks the operand-fetch,
// index, page-fix, data and read-modify-write bus cycles for one addressing mode.
module addressing_sequencer #(
  parameter int         ADDR_W       = 16,
  parameter logic [7:0] ZP_BASE      = 8'h00,
  parameter bit         PAGE_PENALTY = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              rdy,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [1:0]        kind,
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        data_in,
  input  logic [7:0]        index_x,
  input  logic [7:0]        index_y,
  input  logic [7:0]        wdata,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_sel,
  output logic              rw,
  output logic              pc_inc,
  output logic [7:0]        data_out,
  output logic [7:0]        operand,
  output logic              alu_req,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] M_IMP = 3'd0, M_IMM = 3'd1, M_ZPG = 3'd2, M_ZPX = 3'd3,
                         M_ZPY = 3'd4, M_ABX = 3'd6, M_ABY = 3'd7;
  localparam logic [1:0] K_READ = 2'd0, K_WRITE = 2'd1, K_RMW = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_LO, S_FETCH_HI, S_ZP_IDX, S_FIX,
    S_DATA, S_RMW_DUMMY, S_RMW_WRITE, S_DONE
  } state_t;

  state_t      state_q;
  logic [2:0]  mode_q;
  logic [1:0]  kind_q;
  logic [7:0]  lo_q, hi_q, result_q, operand_q;
  logic        carry_q;

  logic [7:0]        idx;
  logic [8:0]        sum_lo;
  logic              abs_indexed;
  logic [ADDR_W-1:0] eff_addr;

  assign idx         = (mode_q == M_ZPY || mode_q == M_ABY) ? index_y : index_x;
  assign sum_lo      = {1'b0, lo_q} + {1'b0, idx};
  assign abs_indexed = (mode_q == M_ABX || mode_q == M_ABY);
  // Bank bits above 15 pass straight through from the PC; the low 16 bits come from hi/lo.
  assign eff_addr    = (pc & ~ADDR_W'(16'hFFFF)) | ADDR_W'({hi_q, lo_q});

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= S_IDLE;
      mode_q    <= M_IMP;
      kind_q    <= K_READ;
      lo_q      <= 8'h00;
      hi_q      <= 8'h00;
      carry_q   <= 1'b0;
      result_q  <= 8'h00;
      operand_q <= 8'h00;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: if (start) begin
          mode_q  <= mode;
          kind_q  <= (mode == M_IMP || mode == M_IMM || kind == 2'd3) ? K_READ : kind;
          state_q <= (mode == M_IMP) ? S_DONE : S_FETCH_LO;
        end
        S_FETCH_LO: begin
          lo_q <= data_in;
          hi_q <= ZP_BASE;  // zero-page modes keep this as their page
          case (mode_q)
            M_IMM: begin
              operand_q <= data_in;
              state_q   <= S_DONE;
            end
            M_ZPG:        state_q <= S_DATA;
            M_ZPX, M_ZPY: state_q <= S_ZP_IDX;
            default:      state_q <= S_FETCH_HI;
          endcase
        end
        S_ZP_IDX: begin
          lo_q    <= sum_lo[7:0];
          state_q <= S_DATA;
        end
        S_FETCH_HI: begin
          hi_q <= data_in;
          if (abs_indexed) {carry_q, lo_q} <= sum_lo;
          if (abs_indexed && (kind_q != K_READ || sum_lo[8] || !PAGE_PENALTY))
            state_q <= S_FIX;
          else
            state_q <= S_DATA;
        end
        S_FIX: begin
          hi_q    <= hi_q + {7'b0, carry_q};
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (kind_q != K_WRITE) operand_q <= data_in;
          state_q <= (kind_q == K_RMW) ? S_RMW_DUMMY : S_DONE;
        end
        S_RMW_DUMMY: begin
          result_q <= wdata;
          state_q  <= S_RMW_WRITE;
        end
        S_RMW_WRITE: state_q <= S_DONE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_sel = 1'b0;
    rw       = 1'b1;
    pc_inc   = 1'b0;
    data_out = 8'h00;
    alu_req  = 1'b0;
    case (state_q)
      S_FETCH_LO, S_FETCH_HI: pc_inc = rdy;
      S_ZP_IDX, S_FIX:        addr_sel = 1'b1;
      S_DATA: begin
        addr_sel = 1'b1;
        if (kind_q == K_WRITE) begin
          rw       = 1'b0;
          data_out = wdata;
        end
      end
      S_RMW_DUMMY: begin
        addr_sel = 1'b1;
        rw       = 1'b0;
        data_out = operand_q;
        alu_req  = rdy;
      end
      S_RMW_WRITE: begin
        addr_sel = 1'b1;
        rw       = 1'b0;
        data_out = result_q;
      end
      default: ;
    endcase
  end

  assign addr    = addr_sel ? eff_addr : '0;
  assign operand = operand_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) && rdy;

endmodule

// File: tb/tb_addressing_sequencer.sv
// Bench for addressing_sequencer: three parameterisations driven from one stimulus,
// bus traces compared against a cycle-count/address model built from the mode rules.
module tb_addressing_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res, rdy, start;
  logic [2:0]  mode;
  logic [1:0]  kind;
  logic [19:0] pc;
  logic [7:0]  data_in, index_x, index_y, wdata;
  logic [15:0] addr0, addr1;
  logic [19:0] addr2;
  logic [2:0]  asel, rw_a, pci, alu, bsy, dn;
  logic [2:0][7:0] dout, oper;

  addressing_sequencer #(.ADDR_W(16), .ZP_BASE(8'h00), .PAGE_PENALTY(1'b1)) dut0 (
    .clk(clk), .res(res), .rdy(rdy), .start(start), .mode(mode), .kind(kind), .pc(pc[15:0]),
    .data_in(data_in), .index_x(index_x), .index_y(index_y), .wdata(wdata), .addr(addr0),
    .addr_sel(asel[0]), .rw(rw_a[0]), .pc_inc(pci[0]), .data_out(dout[0]), .operand(oper[0]),
    .alu_req(alu[0]), .busy(bsy[0]), .done(dn[0]));
  addressing_sequencer #(.ADDR_W(16), .ZP_BASE(8'h00), .PAGE_PENALTY(1'b0)) dut1 (
    .clk(clk), .res(res), .rdy(rdy), .start(start), .mode(mode), .kind(kind), .pc(pc[15:0]),
    .data_in(data_in), .index_x(index_x), .index_y(index_y), .wdata(wdata), .addr(addr1),
    .addr_sel(asel[1]), .rw(rw_a[1]), .pc_inc(pci[1]), .data_out(dout[1]), .operand(oper[1]),
    .alu_req(alu[1]), .busy(bsy[1]), .done(dn[1]));
  addressing_sequencer #(.ADDR_W(20), .ZP_BASE(8'h03), .PAGE_PENALTY(1'b1)) dut2 (
    .clk(clk), .res(res), .rdy(rdy), .start(start), .mode(mode), .kind(kind), .pc(pc),
    .data_in(data_in), .index_x(index_x), .index_y(index_y), .wdata(wdata), .addr(addr2),
    .addr_sel(asel[2]), .rw(rw_a[2]), .pc_inc(pci[2]), .data_out(dout[2]), .operand(oper[2]),
    .alu_req(alu[2]), .busy(bsy[2]), .done(dn[2]));

  int n_chk = 0, n_fail = 0;
  int sel = 0;
  logic [19:0] pc_mask = 20'h0FFFF;
  logic [2:0]  cur_mode = 3'd0;
  logic [1:0]  cur_kind = 2'd0;
  logic [7:0]  mem [logic [19:0]];

  // Pre-edge sample of the selected DUT
  logic [19:0] s_addr, s_bus;
  logic        s_sel, s_rw, s_inc, s_alu, s_busy, s_done;
  logic [7:0]  s_dout, s_oper;

  function automatic logic [7:0] rdmem(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
  endfunction

  function automatic string fa(input logic [19:0] a);
    return $sformatf("%05h ", a);
  endfunction

  function automatic string fw(input logic [19:0] a, input logic [7:0] d);
    return $sformatf("%05h=%02h ", a, d);
  endfunction

  task automatic tick(input bit r, input bit s, input bit rs);
    @(negedge clk);
    rdy = r; start = s; res = rs;
    if (s) begin
      mode = cur_mode; kind = cur_kind;
    end else begin
      mode = 3'($urandom); kind = 2'($urandom);
    end
    #1;
    s_addr = (sel == 2) ? addr2 : (sel == 1) ? {4'h0, addr1} : {4'h0, addr0};
    s_sel = asel[sel]; s_rw = rw_a[sel]; s_inc = pci[sel]; s_alu = alu[sel];
    s_busy = bsy[sel]; s_done = dn[sel]; s_dout = dout[sel]; s_oper = oper[sel];
    s_bus = s_sel ? s_addr : pc;
    data_in = s_rw ? rdmem(s_bus) : 8'($urandom);
    @(posedge clk);
    #1;
    if (s_inc && !rs) pc = (pc + 20'd1) & pc_mask;
  endtask

  task automatic test_sequence(input string name, input int cfg, input bit do_rst,
      input logic [2:0] md, input logic [1:0] kd, input logic [19:0] pc0,
      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] x, input logic [7:0] y,
      input logic [7:0] wd, input logic [19:0] ex_a, input logic [7:0] ex_v,
      input int stall_pct, input int stall_at, input int stall_n);
    logic [19:0] msk, bank, ea;
    logic [7:0]  zpb, idx, e_op;
    bit          pp, fin, have_ref, r, r_sel, r_rw;
    int          ek, e_cyc, e_pci, e_alu, o_cyc, o_pci, o_alu, rbusy, planned;
    string       e_rd, e_wr, o_rd, o_wr;
    logic [19:0] r_addr;
    logic [7:0]  r_dout;
    // Expected behaviour from the addressing-mode rules
    msk = (cfg == 2) ? 20'hFFFFF : 20'h0FFFF;
    zpb = (cfg == 2) ? 8'h03 : 8'h00;
    pp = (cfg != 1);
    bank = pc0 & 20'hF0000 & msk;
    ek = (md <= 3'd1 || kd == 2'd3) ? 0 : int'(kd);
    idx = (md == 3'd4 || md == 3'd7) ? y : x;
    mem.delete();
    mem[ex_a] = ex_v;
    mem[pc0] = b0;
    mem[(pc0 + 20'd1) & msk] = b1;
    e_op = 8'h00; e_alu = 0; e_cyc = 1; e_pci = 0; e_rd = ""; e_wr = "";
    if (md == 3'd1) begin
      e_pci = 1; e_rd = fa(pc0); e_op = b0; e_cyc = 2;
    end else if (md != 3'd0) begin
      e_pci = (md >= 3'd5) ? 2 : 1;
      e_rd = fa(pc0);
      if (md >= 3'd5) e_rd = {e_rd, fa((pc0 + 20'd1) & msk)};
      if (md <= 3'd4) begin
        if (md != 3'd2) begin
          e_rd = {e_rd, fa(bank | {12'h0, zpb, b0})}; e_cyc++;
        end
        ea = bank | {4'h0, zpb, (md == 3'd2) ? b0 : 8'(b0 + idx)};
      end else if (md == 3'd5) begin
        ea = bank | {4'h0, b1, b0};
      end else begin
        if (ek != 0 || int'(b0) + int'(idx) > 255 || !pp) begin
          e_rd = {e_rd, fa(bank | {4'h0, b1, 8'(b0 + idx)})}; e_cyc++;
        end
        ea = bank | {4'h0, 16'({b1, b0} + {8'h00, idx})};
      end
      e_cyc += e_pci + 1;
      if (ek != 1) begin
        e_rd = {e_rd, fa(ea)}; e_op = rdmem(ea);
      end
      if (ek == 1) e_wr = fw(ea, wd);
      if (ek == 2) begin
        e_wr = {fw(ea, rdmem(ea)), fw(ea, wd)}; e_alu = 1; e_cyc += 2;
      end
    end
    // Drive the sequence
    sel = cfg; pc_mask = msk; pc = pc0; index_x = x; index_y = y; wdata = wd;
    cur_mode = md; cur_kind = kd;
    if (do_rst) tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    o_cyc = 0; o_pci = 0; o_alu = 0; o_rd = ""; o_wr = "";
    fin = 0; have_ref = 0; rbusy = 0; planned = 0;
    r_addr = '0; r_sel = 0; r_rw = 0; r_dout = '0;
    for (int i = 0; i < 100 && !fin; i++) begin
      r = 1'b1;
      if (rbusy == stall_at && planned < stall_n) begin
        r = 1'b0; planned++;
      end else if ($urandom_range(99) < stall_pct) r = 1'b0;
      tick(r, 1'b0, 1'b0);
      if (!r) begin
        n_chk++;
        if ({s_inc, s_alu, s_done} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s stall_strobes: got inc/alu/done=%b%b%b required 000", name, s_inc, s_alu, s_done);
        end
      end
      if (have_ref) begin
        n_chk++;
        if ({s_addr, s_sel, s_rw, s_dout} !== {r_addr, r_sel, r_rw, r_dout}) begin
          n_fail++;
          $display("FAIL %s stall_hold: got %h/%b/%b/%h required %h/%b/%b/%h", name,
                   s_addr, s_sel, s_rw, s_dout, r_addr, r_sel, r_rw, r_dout);
        end
      end
      if (!r) begin
        if (!have_ref) begin
          r_addr = s_addr; r_sel = s_sel; r_rw = s_rw; r_dout = s_dout; have_ref = 1;
        end
      end else begin
        have_ref = 0;
        if (s_busy) begin
          rbusy++; o_cyc++;
          o_pci += int'(s_inc); o_alu += int'(s_alu);
          if (s_done) fin = 1;
          else if (s_rw) o_rd = {o_rd, fa(s_bus)};
          else o_wr = {o_wr, fw(s_bus, s_dout)};
        end
      end
    end
    n_chk++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: got no done within 100 cycles required done", name);
    end
    tick(1'b1, 1'b0, 1'b0);
    n_chk++;
    if ({s_busy, s_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s idle_after_done: got busy/done=%b%b required 00", name, s_busy, s_done);
    end
    n_chk++;
    if (o_cyc !== e_cyc) begin
      n_fail++; $display("FAIL %s cycles: got %0d required %0d", name, o_cyc, e_cyc);
    end
    n_chk++;
    if (o_pci !== e_pci) begin
      n_fail++; $display("FAIL %s pc_inc_count: got %0d required %0d", name, o_pci, e_pci);
    end
    n_chk++;
    if (o_alu !== e_alu) begin
      n_fail++; $display("FAIL %s alu_req_count: got %0d required %0d", name, o_alu, e_alu);
    end
    n_chk++;
    if (s_oper !== e_op) begin
      n_fail++; $display("FAIL %s operand: got %h required %h", name, s_oper, e_op);
    end
    n_chk++;
    if (o_rd != e_rd) begin
      n_fail++; $display("FAIL %s read_trace: got [%s] required [%s]", name, o_rd, e_rd);
    end
    n_chk++;
    if (o_wr != e_wr) begin
      n_fail++; $display("FAIL %s write_trace: got [%s] required [%s]", name, o_wr, e_wr);
    end
  endtask

  task automatic test_reset;
    sel = 0; pc_mask = 20'h0FFFF; pc = 20'h0800; mem.delete();
    cur_mode = 3'd6; cur_kind = 2'd2; index_x = 8'hF3; wdata = 8'h66;
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    n_chk++;
    if ({s_addr, s_sel, s_rw, s_inc, s_dout, s_oper, s_alu, s_busy, s_done} !==
        {20'h0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h sel=%b rw=%b inc=%b dout=%h op=%h alu=%b busy=%b done=%b required 0/0/1/0/00/00/0/0/0",
               s_addr, s_sel, s_rw, s_inc, s_dout, s_oper, s_alu, s_busy, s_done);
    end
  endtask

  task automatic test_reset_abort;
    int writes;
    sel = 0; pc_mask = 20'h0FFFF; pc = 20'h0200; mem.delete();
    mem[20'h00200] = 8'h42; mem[20'h00042] = 8'h81; wdata = 8'h02;
    cur_mode = 3'd2; cur_kind = 2'd2;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    n_chk++;
    if ({s_alu, s_rw, s_dout} !== {1'b1, 1'b0, 8'h81}) begin
      n_fail++;
      $display("FAIL abort_in_rmw_dummy: got alu=%b rw=%b dout=%h required 1/0/81", s_alu, s_rw, s_dout);
    end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        n_chk++;
        if ({s_busy, s_rw} !== 2'b01) begin
          n_fail++; $display("FAIL abort_next_cycle: got busy/rw=%b%b required 01", s_busy, s_rw);
        end
      end
      if (!s_rw) writes++;
    end
    n_chk++;
    if (writes !== 0) begin
      n_fail++; $display("FAIL abort_no_write: got %0d write cycles required 0", writes);
    end
    test_sequence("restart_after_abort", 0, 1'b0, 3'd2, 2'd0, 20'h0300, 8'h77, 8'h00,
                  8'h00, 8'h00, 8'h00, 20'h00077, 8'hB4, 0, -1, 0);
  endtask

  task automatic test_zero_page;
    test_sequence("zpx_read_wrap", 0, 1'b1, 3'd3, 2'd0, 20'h0400, 8'hF0, 8'h00,
                  8'h20, 8'h00, 8'h00, 20'h00010, 8'h5A, 0, -1, 0);
    test_sequence("zpy_write", 0, 1'b1, 3'd4, 2'd1, 20'h1000, 8'h30, 8'h00,
                  8'h99, 8'h05, 8'hE7, 20'h00035, 8'h11, 0, -1, 0);
    test_sequence("zpg_read_k3", 0, 1'b1, 3'd2, 2'd3, 20'h2000, 8'h80, 8'h00,
                  8'h00, 8'h00, 8'h00, 20'h00080, 8'hA7, 0, -1, 0);
  endtask

  task automatic test_absolute_indexed;
    test_sequence("abx_read_nocross", 0, 1'b1, 3'd6, 2'd0, 20'h0600, 8'h10, 8'h12,
                  8'h05, 8'h00, 8'h00, 20'h01215, 8'h3D, 0, -1, 0);
    test_sequence("abx_read_cross", 0, 1'b1, 3'd6, 2'd0, 20'h0600, 8'hFF, 8'h12,
                  8'h01, 8'h00, 8'h00, 20'h01300, 8'h9E, 0, -1, 0);
    test_sequence("aby_write", 0, 1'b1, 3'd7, 2'd1, 20'h0700, 8'h20, 8'h40,
                  8'h00, 8'h04, 8'h5C, 20'h04024, 8'h00, 0, -1, 0);
    test_sequence("abs_read", 0, 1'b1, 3'd5, 2'd0, 20'hFFFF, 8'h34, 8'h12,
                  8'h00, 8'h00, 8'h00, 20'h01234, 8'hC8, 0, -1, 0);
    test_sequence("imp", 0, 1'b1, 3'd0, 2'd1, 20'h0100, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 20'h00000, 8'h00, 0, -1, 0);
    test_sequence("imm", 0, 1'b1, 3'd1, 2'd2, 20'h0100, 8'hD3, 8'h00,
                  8'h00, 8'h00, 8'h00, 20'h00000, 8'h00, 0, -1, 0);
  endtask

  task automatic test_page_penalty;
    test_sequence("np_abx_nocross", 1, 1'b1, 3'd6, 2'd0, 20'h0600, 8'h10, 8'h12,
                  8'h05, 8'h00, 8'h00, 20'h01215, 8'h3D, 0, -1, 0);
    test_sequence("np_abx_cross", 1, 1'b1, 3'd6, 2'd0, 20'h0600, 8'hFF, 8'h12,
                  8'h01, 8'h00, 8'h00, 20'h01300, 8'h9E, 0, -1, 0);
  endtask

  task automatic test_rmw;
    test_sequence("rmw_zpg", 0, 1'b1, 3'd2, 2'd2, 20'h0500, 8'h42, 8'h00,
                  8'h00, 8'h00, 8'h02, 20'h00042, 8'h81, 0, -1, 0);
    test_sequence("rmw_abx", 0, 1'b1, 3'd6, 2'd2, 20'h0500, 8'hF8, 8'h21,
                  8'h10, 8'h00, 8'h4B, 20'h02208, 8'h6E, 0, -1, 0);
  endtask

  task automatic test_stall;
    test_sequence("abs_write_stall", 0, 1'b1, 3'd5, 2'd1, 20'h0900, 8'h56, 8'h34,
                  8'h00, 8'h00, 8'hC3, 20'h03456, 8'h00, 0, 1, 3);
  endtask

  task automatic test_banked;
    test_sequence("bank_zpg", 2, 1'b1, 3'd2, 2'd0, 20'h51234, 8'h42, 8'h00,
                  8'h00, 8'h00, 8'h00, 20'h50342, 8'hE1, 0, -1, 0);
    test_sequence("bank_abx_rmw", 2, 1'b1, 3'd6, 2'd2, 20'hA0FF0, 8'hFE, 8'hFF,
                  8'h03, 8'h00, 8'h17, 20'hA0001, 8'h2B, 20, -1, 0);
  endtask

  task automatic test_random;
    int cfg;
    logic [19:0] p;
    for (int n = 0; n < 40; n++) begin
      cfg = int'($urandom_range(2));
      if (cfg == 2) p = {4'($urandom_range(1, 15)), 16'($urandom_range(0, 16'hFF00))};
      else p = 20'($urandom_range(0, 16'hFFFF));
      test_sequence($sformatf("random_%0d", n), cfg, 1'b1, 3'($urandom), 2'($urandom), p,
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    20'($urandom), 8'($urandom), 25, -1, 0);
    end
  endtask

  initial begin
    res = 1'b1; rdy = 1'b1; start = 1'b0; mode = '0; kind = '0; pc = '0;
    data_in = '0; index_x = '0; index_y = '0; wdata = '0;
    tick(1'b1, 1'b0, 1'b1);
    test_reset();
    test_zero_page();
    test_absolute_indexed();
    test_page_penalty();
    test_rmw();
    test_stall();
    test_banked();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
